// File: rtl/trng_pkg.sv
// trng_pkg: shared FSM encoding and default sizing for trng_ctrl.
// Imported by trng_ctrl and trng_health.
package trng_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_SAMPLE,
    ST_SEND,
    ST_DONE
  } state_t;

  localparam int unsigned DEF_WARMUP_CYC = 256;
  localparam int unsigned DEF_NUM_BYTES  = 16;
  localparam int unsigned DEF_REP_LIMIT  = 4;

endpackage

// File: rtl/trng_health.sv
// trng_health: repetition-count test over transferred bytes.
// Flags o_fail combinationally on the strobe that completes the run.
module trng_health
  import trng_pkg::*;
#(
  parameter int REP_LIMIT = DEF_REP_LIMIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clear,
  input  logic       i_strobe,
  input  logic [7:0] i_byte,
  output logic       o_fail
);

  localparam logic [3:0] RUN_MAX = 4'(REP_LIMIT - 1);

  logic [7:0] r_prev;
  logic [3:0] r_run;
  logic       r_have;
  logic       w_same;

  assign w_same = r_have & (i_byte == r_prev);
  assign o_fail = i_strobe & w_same & (r_run == RUN_MAX);

  // Track previous byte and length of the current identical run
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev <= 8'd0;
      r_run  <= 4'd0;
      r_have <= 1'b0;
    end else if (i_clear) begin
      r_prev <= 8'd0;
      r_run  <= 4'd1;
      r_have <= 1'b0;
    end else if (i_strobe) begin
      r_prev <= i_byte;
      r_have <= 1'b1;
      r_run  <= w_same ? r_run + 4'd1 : 4'd1;
    end
  end

endmodule

// File: rtl/trng_ctrl.sv
// trng_ctrl: warmup / sample / send sequencer for a ring-oscillator TRNG.
// Define TRNG_HEALTH_EN to add the repetition health test and err flag.
module trng_ctrl
  import trng_pkg::*;
#(
  parameter int WARMUP_CYC = DEF_WARMUP_CYC,
  parameter int NUM_BYTES  = DEF_NUM_BYTES,
  parameter int REP_LIMIT  = DEF_REP_LIMIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       abort,
  input  logic       trng_bit,
  output logic       ro_en,
  output logic       core_start,
  input  logic       tx_rdy,
  output logic [7:0] tx_data,
  output logic       tx_vld,
  output logic       busy,
  output logic       done,
  output logic       err
);

  if (WARMUP_CYC < 1 || WARMUP_CYC > 65535) begin : g_bad_warmup
    $error("trng_ctrl: WARMUP_CYC out of range");
  end
  if (NUM_BYTES < 1 || NUM_BYTES > 255) begin : g_bad_bytes
    $error("trng_ctrl: NUM_BYTES out of range");
  end
  if (REP_LIMIT < 2 || REP_LIMIT > 15) begin : g_bad_rep
    $error("trng_ctrl: REP_LIMIT out of range");
  end

  localparam logic [15:0] W_LAST = 16'(WARMUP_CYC - 1);
  localparam logic [7:0]  B_LAST = 8'(NUM_BYTES - 1);

  state_t      r_state;
  logic [15:0] r_wcnt;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_byte_cnt;
  logic [7:0]  r_byte;
  logic        r_ro_en;
  logic        r_core_start;
  logic        r_tx_vld;
  logic        r_busy;
  logic        r_done;

  logic        w_xfer;
  logic        w_fail;
  logic        w_abort;

  assign w_xfer  = r_tx_vld & tx_rdy;
  assign w_abort = abort & (r_state != ST_IDLE);

  assign ro_en      = r_ro_en;
  assign core_start = r_core_start;
  assign tx_data    = r_byte;
  assign tx_vld     = r_tx_vld;
  assign busy       = r_busy;
  assign done       = r_done;

`ifdef TRNG_HEALTH_EN
  logic r_err;
  logic w_start;

  assign w_start = (r_state == ST_IDLE) & req;
  assign err     = r_err;

  trng_health #(
    .REP_LIMIT(REP_LIMIT)
  ) u_health (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_start),
    .i_strobe(w_xfer),
    .i_byte  (r_byte),
    .o_fail  (w_fail)
  );

  // Sticky error: cleared by an accepted request, set by a failed byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_start) begin
      r_err <= 1'b0;
    end else if (w_fail & ~w_abort) begin
      r_err <= 1'b1;
    end
  end
`else
  assign w_fail = 1'b0;
  assign err    = 1'b0;
`endif

  // Burst sequencer with outputs registered alongside the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_wcnt       <= 16'd0;
      r_bit_cnt    <= 3'd0;
      r_byte_cnt   <= 8'd0;
      r_byte       <= 8'd0;
      r_ro_en      <= 1'b0;
      r_core_start <= 1'b0;
      r_tx_vld     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_abort || (w_xfer && w_fail)) begin
        r_state      <= ST_IDLE;
        r_wcnt       <= 16'd0;
        r_bit_cnt    <= 3'd0;
        r_byte_cnt   <= 8'd0;
        r_byte       <= 8'd0;
        r_ro_en      <= 1'b0;
        r_core_start <= 1'b0;
        r_tx_vld     <= 1'b0;
        r_busy       <= 1'b0;
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (req) begin
              r_state <= ST_WARMUP;
              r_wcnt  <= 16'd0;
              r_ro_en <= 1'b1;
              r_busy  <= 1'b1;
            end
          end
          ST_WARMUP: begin
            if (r_wcnt == W_LAST) begin
              r_state      <= ST_SAMPLE;
              r_wcnt       <= 16'd0;
              r_bit_cnt    <= 3'd0;
              r_core_start <= 1'b1;
            end else begin
              r_wcnt <= r_wcnt + 16'd1;
            end
          end
          ST_SAMPLE: begin
            r_byte[r_bit_cnt] <= trng_bit;
            r_bit_cnt         <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_state      <= ST_SEND;
              r_core_start <= 1'b0;
              r_tx_vld     <= 1'b1;
            end
          end
          ST_SEND: begin
            if (w_xfer) begin
              r_tx_vld <= 1'b0;
              if (r_byte_cnt == B_LAST) begin
                r_state    <= ST_DONE;
                r_byte_cnt <= 8'd0;
                r_ro_en    <= 1'b0;
                r_done     <= 1'b1;
              end else begin
                r_state      <= ST_SAMPLE;
                r_byte_cnt   <= r_byte_cnt + 8'd1;
                r_bit_cnt    <= 3'd0;
                r_core_start <= 1'b1;
              end
            end
          end
          ST_DONE: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
